// File: rtl/fpm_operand_stage.sv
// Handshake wrapper for the combinational single-precision multiplier: operand FIFO in, registered product out.
// Optional exponent-range flags on out_exc are enabled with `define FPM_STAGE_EXC_EN.
module fpm_operand_stage #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [1:0]  out_exc
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } pair_t;

  pair_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop, out_free, not_empty;
  pair_t         head;

  assign not_empty = (count != '0);
  assign in_ready  = (count != FULL);
  assign push      = in_valid && in_ready;
  assign out_free  = !out_valid || out_ready;
  assign pop       = not_empty && out_free;
  assign head      = mem[rd_ptr];
  assign mul_a     = not_empty ? head.a : 32'h0;
  assign mul_b     = not_empty ? head.b : 32'h0;

  // Storage needs no reset; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{a: in_a, b: in_b};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= 32'h0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        out_data  <= mul_result;
        out_valid <= 1'b1;
      end else if (out_ready && out_valid) begin
        out_valid <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef FPM_STAGE_EXC_EN
  logic [7:0] ea, eb;
  logic [9:0] esum;
  logic       ovf, unf;

  assign ea   = mul_a[30:23];
  assign eb   = mul_b[30:23];
  assign esum = {2'b00, ea} + {2'b00, eb};
  // Biased-sum test only; a 381 sum that carries out of the mantissa is not caught.
  assign ovf  = (ea != 8'd0) && (eb != 8'd0) && (esum >= 10'd382);
  assign unf  = (ea != 8'd0) && (eb != 8'd0) && (esum <= 10'd127);

  always_ff @(posedge clk) begin
    if (!rst_n)   out_exc <= 2'b00;
    else if (pop) out_exc <= {ovf, unf};
  end
`else
  assign out_exc = 2'b00;
`endif

endmodule

// File: tb/tb_fpm_operand_stage.sv
// Self-checking bench for fpm_operand_stage; a behavioural float multiplier stands in for fpm.
module tb_fpm_operand_stage;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic [31:0] mul_a, mul_b;
  logic [31:0] mul_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_exc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fpm_operand_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_exc(out_exc)
  );

  // Truncating float multiply for normal operands; zero/denormal inputs give signed zero.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          e;
    logic [47:0] p;
    logic [22:0] m;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'b0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin m = p[46:24]; e = e + 1; end
    else       m = p[45:23];
    if (e >= 255) return {s, 8'hFF, 23'b0};
    if (e <= 0)   return {s, 31'b0};
    return {s, e[7:0], m};
  endfunction

  function automatic logic [1:0] exc_of(input logic [31:0] a, input logic [31:0] b);
`ifdef FPM_STAGE_EXC_EN
    int ea, eb;
    logic o, u;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    o = (ea != 0) && (eb != 0) && (ea + eb >= 382);
    u = (ea != 0) && (eb != 0) && (ea + eb <= 127);
    return {o, u};
`else
    return 2'b00;
`endif
  endfunction

  assign mul_result = fmul(mul_a, mul_b);

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    checks++; if (out_exc !== 2'b00) begin failures++; $display("FAIL reset_out_exc got=%b want=00", out_exc); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (mul_a !== 32'h0 || mul_b !== 32'h0) begin failures++; $display("FAIL reset_mul_empty got=%h/%h want=0/0", mul_a, mul_b); end
  endtask

  task automatic test_latency();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 32'h40000000; in_b = 32'h40400000;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lat_early_valid got=%b want=0", out_valid); end
    checks++; if (mul_a !== 32'h40000000 || mul_b !== 32'h40400000) begin failures++; $display("FAIL lat_head got=%h/%h want=40000000/40400000", mul_a, mul_b); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL lat_valid got=%b want=1", out_valid); end
    checks++; if (out_data !== 32'h40C00000) begin failures++; $display("FAIL lat_data got=%h want=40c00000", out_data); end
    checks++; if (out_exc !== 2'b00) begin failures++; $display("FAIL lat_exc got=%b want=00", out_exc); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 32'h3FC00000; in_b = 32'h3FC00000;
    @(posedge clk); @(negedge clk);
    in_a = 32'h00000000; in_b = 32'h40400000;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h40100000) begin failures++; $display("FAIL b2b_first got=%b/%h want=1/40100000", out_valid, out_data); end
    @(posedge clk); @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h00000000) begin failures++; $display("FAIL b2b_second got=%b/%h want=1/00000000", out_valid, out_data); end
  endtask

  task automatic test_backpressure();
    logic [31:0] ea [$];
    int got;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      in_valid = 1'b1;
      in_a = 32'h3F800000 + (i << 20);
      in_b = 32'h40000000 + (i << 19);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_accept%0d got=%b want=1", i, in_ready); end
      ea.push_back(fmul(in_a, in_b));
      @(posedge clk); @(negedge clk);
    end
    in_a = 32'h41000000; in_b = 32'h41000000;
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full%0d got=%b want=0", i, in_ready); end
      checks++; if (out_valid !== 1'b1 || out_data !== ea[0]) begin failures++; $display("FAIL bp_hold%0d got=%b/%h want=1/%h", i, out_valid, out_data, ea[0]); end
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && ea.size() != 0; c++) begin
      if (out_valid) begin
        checks++; if (out_data !== ea[0]) begin failures++; $display("FAIL bp_drain%0d got=%h want=%h", got, out_data, ea[0]); end
        void'(ea.pop_front());
        got++;
      end
      @(posedge clk); @(negedge clk);
    end
    checks++; if (got != DEPTH + 1) begin failures++; $display("FAIL bp_drain_count got=%0d want=%0d", got, DEPTH + 1); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_after_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_full_pop();
    logic [31:0] ea [$];
    int got;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      in_valid = 1'b1;
      in_a = 32'h40800000 + (i << 18);
      in_b = 32'h3F000000 + (i << 21);
      if (i > 0) ea.push_back(fmul(in_a, in_b));
      @(posedge clk); @(negedge clk);
    end
    // Full FIFO, simultaneous pop and push offer: the push must be refused.
    in_valid = 1'b1; in_a = 32'h4B000000; in_b = 32'h4B000000; out_ready = 1'b1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fp_refuse got=%b want=0", in_ready); end
    @(posedge clk); @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fp_reopen got=%b want=1", in_ready); end
    out_ready = 1'b0;
    in_a = 32'h42000000; in_b = 32'h40400000;
    ea.push_back(fmul(in_a, in_b));
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fp_count_depth_minus1 got=%b want=0", in_ready); end
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && ea.size() != 0; c++) begin
      if (out_valid) begin
        checks++; if (out_data !== ea[0]) begin failures++; $display("FAIL fp_drain%0d got=%h want=%h", got, out_data, ea[0]); end
        void'(ea.pop_front());
        got++;
      end
      @(posedge clk); @(negedge clk);
    end
    checks++; if (got != DEPTH + 1 || out_valid !== 1'b0) begin failures++; $display("FAIL fp_drain_count got=%0d/%b want=%0d/0", got, out_valid, DEPTH + 1); end
  endtask

  task automatic test_exc();
    logic [31:0] av [2];
    logic [1:0]  want;
    bit          seen;
    av[0] = 32'h7F000000;
    av[1] = 32'h01000000;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_a = av[k]; in_b = av[k];
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 5 && !seen; c++) begin
        @(posedge clk); @(negedge clk);
        seen = out_valid;
      end
`ifdef FPM_STAGE_EXC_EN
      want = (k == 0) ? 2'b10 : 2'b01;
`else
      want = 2'b00;
`endif
      checks++; if (!seen) begin failures++; $display("FAIL exc%0d_timeout got=0 want=1", k); end
      checks++; if (out_exc !== want) begin failures++; $display("FAIL exc%0d_flags got=%b want=%b", k, out_exc, want); end
      checks++; if (out_data !== fmul(av[k], av[k])) begin failures++; $display("FAIL exc%0d_data got=%h want=%h", k, out_data, fmul(av[k], av[k])); end
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_reset_inflight();
    int stale;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = 32'h40A00000 + (i << 16); in_b = 32'h40E00000;
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rif_pre_valid got=%b want=1", out_valid); end
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rif_valid got=%b want=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL rif_data got=%h want=0", out_data); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rif_in_ready got=%b want=1", in_ready); end
    out_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    checks++; if (stale != 0) begin failures++; $display("FAIL rif_stale got=%0d want=0", stale); end
  endtask

  task automatic test_random();
    logic [63:0] q [$];
    logic        mov;
    logic [31:0] mod;
    logic [1:0]  moe;
    logic        exp_ready, free;
    logic [31:0] ha, hb;
    do_reset();
    mov = 1'b0; mod = '0; moe = 2'b00;
    for (int cyc = 0; cyc < 400; cyc++) begin
      exp_ready = (q.size() != DEPTH);
      ha = (q.size() != 0) ? q[0][63:32] : 32'h0;
      hb = (q.size() != 0) ? q[0][31:0]  : 32'h0;
      checks++; if (in_ready !== exp_ready) begin failures++; $display("FAIL rnd_in_ready c%0d got=%b want=%b", cyc, in_ready, exp_ready); end
      checks++; if (out_valid !== mov) begin failures++; $display("FAIL rnd_out_valid c%0d got=%b want=%b", cyc, out_valid, mov); end
      checks++; if (mul_a !== ha || mul_b !== hb) begin failures++; $display("FAIL rnd_head c%0d got=%h/%h want=%h/%h", cyc, mul_a, mul_b, ha, hb); end
      if (mov) begin
        checks++; if (out_data !== mod || out_exc !== moe) begin failures++; $display("FAIL rnd_out c%0d got=%h/%b want=%h/%b", cyc, out_data, out_exc, mod, moe); end
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = $urandom;
      in_b      = $urandom;
      out_ready = (cyc < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      free = !mov || out_ready;
      if (q.size() != 0 && free) begin
        mod = fmul(q[0][63:32], q[0][31:0]);
        moe = exc_of(q[0][63:32], q[0][31:0]);
        mov = 1'b1;
        void'(q.pop_front());
      end else if (out_ready && mov) begin
        mov = 1'b0;
      end
      if (in_valid && exp_ready) q.push_back({in_a, in_b});
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    test_reset();
    test_latency();
    test_back_to_back();
    test_backpressure();
    test_full_pop();
    test_exc();
    test_reset_inflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpm_operand_stage.md
# fpm_operand_stage

Registered handshake stage wrapped around the combinational single-precision multiplier (`fpm`). It buffers IEEE-754 operand pairs in a small FIFO and presents the head pair to the multiplier. It then captures the multiplier's product into an output register with valid/ready flow control. This gives the combinational core a clean one-pair-per-cycle streaming interface to the rest of the chip.

## Interface
- `DEPTH`, 4, number of operand-pair FIFO entries; power of two, ≥2.
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `in_valid`  input  1  upstream offers `in_a`/`in_b`.
- `in_ready`  output  1  stage can accept a pair this cycle.
- `in_a`, `in_b`  input  32 each  operands, IEEE-754 single.
- `mul_a`, `mul_b`  output  32 each  head pair, driven to the multiplier's `in1`/`in2`.
- `mul_result`  input  32  multiplier's combinational `out`.
- `out_valid`  output  1  `out_data` holds a product.
- `out_ready`  input  1  downstream takes `out_data`.
- `out_data`  output  32  registered product.
- `out_exc`  output  2  {ovf, unf} exponent-range flags for `out_data`.

## Operation
- Push: `in_valid && in_ready` writes {`in_a`,`in_b`} at the write pointer.
- `in_ready = (count != DEPTH)`, from registered count only. There is no pass-through when full.
- `mul_a`/`mul_b` show the head entry combinationally from the read pointer. They read 0 when the FIFO is empty.
- Output register free: `!out_valid || out_ready`.
- Pop/capture: when count ≠ 0 and the output register is free:
  - `out_data ← mul_result`, `out_valid ← 1`, read pointer advances.
- Otherwise, `out_ready && out_valid` clears `out_valid`. `out_data` holds its value.
- Count: push and pop in the same cycle leaves count unchanged. Pointers are `log2(DEPTH)` bits and wrap modulo DEPTH.
- Order is strict FIFO. No entry is dropped or duplicated.
- Reset (`rst_n` low at an edge) clears state regardless of in-flight data:
  - count = 0, both pointers = 0.
  - `out_valid` = 0, `out_data` = 0, `out_exc` = 0.
  - FIFO contents are don't-care.
- In the reset cycle `in_ready` reads 1 once `rst_n` is high, because it depends only on count.

## Timing
- Latency: a pair pushed at edge k reaches `mul_a`/`mul_b` in cycle k+1. It is captured at edge k+1, and `out_valid` is high from cycle k+2. This holds when the FIFO was empty and the output register was free.
- Throughput: one pair per cycle with `out_ready` held high.
- Backpressure: with `out_ready` low, `out_valid` and `out_data` stay stable. The FIFO fills and `in_ready` drops in the cycle after count reaches DEPTH.
- Full with simultaneous pop: `in_ready` is still 0 that cycle and the push is refused. It rises the next cycle.
- Empty with `in_valid`: there is no same-cycle bypass. The minimum latency is always 2 edges.

## Configuration
- `FPM_STAGE_EXC_EN` defined: at capture, `out_exc` is registered from the head exponents `ea = mul_a[30:23]`, `eb = mul_b[30:23]`, using a 10-bit sum `s = ea + eb`.
  - ovf = (ea ≠ 0 && eb ≠ 0 && s ≥ 382).
  - unf = (ea ≠ 0 && eb ≠ 0 && s ≤ 127).
  - `s` = 381 with mantissa carry is not flagged (documented limit).
- Not defined: `out_exc` is held at 2'b00 and no exponent logic is synthesized.

## Test plan
- Reset, then push 0x40000000 × 0x40400000 at edge k -> `out_valid` first high in cycle k+2 with `out_data` = 0x40C00000 and `out_exc` = 00.
- Stream 0x3FC00000 × 0x3FC00000, then 0x00000000 × 0x40400000, back-to-back with `out_ready` = 1 -> outputs 0x40100000 then 0x00000000 on consecutive cycles.
- Hold `out_ready` = 0 and push DEPTH+1 = 5 distinct pairs -> 4 pushes accepted plus 1 captured; `in_ready` = 0 thereafter. Raising `out_ready` drains the products in push order, with none lost.
- Full FIFO with a simultaneous pop and `in_valid` = 1 -> the push is refused that cycle, `in_ready` = 1 next cycle, and count = DEPTH−1.
- With `FPM_STAGE_EXC_EN`: 0x7F000000 × 0x7F000000 -> `out_exc` = 2'b10. Then 0x01000000 × 0x01000000 -> `out_exc` = 2'b01. Without the macro, both cases give `out_exc` = 00.
- Assert `rst_n` = 0 with 3 pairs queued and `out_valid` = 1 -> next cycle `out_valid` = 0, `out_data` = 0, `in_ready` = 1, and no stale product emerges afterwards.
